// File: rtl/mc_datapath_core.sv
// Multi-cycle datapath core: PC, IMEM, 32-entry register bank and ALU
// sequenced FETCH/DECODE/EXEC/WB by a control FSM with a program-load port.
module mc_datapath_core #(
    parameter int          XLEN       = 32,
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] PC_RESET   = 32'h0,
    localparam int         AW         = $clog2(IMEM_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            imem_we,
    input  logic [AW-1:0]   imem_waddr,
    input  logic [31:0]     imem_wdata,
    input  logic            run,
    output logic [XLEN-1:0] out_G,
    output logic            out_valid,
    output logic            busy,
    output logic            halted,
    output logic [31:0]     pc_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);

    state_t state;
    state_t state_nxt;

    logic [31:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] regs [32];

    logic [31:0]     pc;
    logic [31:0]     ir;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] y;
    logic [4:0]      dest;
    logic            wb_en;

    logic [5:0]      op;
    logic [5:0]      funct;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [31:0]     off32;
    logic [31:0]     pc_inc;
    logic [31:0]     pc_br;
    logic            is_r;
    logic            is_addi;
    logic            is_beq;

    logic [XLEN-1:0] y_nxt;
    logic [4:0]      dest_nxt;
    logic            wb_nxt;
    logic            take;

    assign op      = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign funct   = ir[5:0];
    assign imm     = XLEN'($signed(ir[15:0]));
    assign off32   = 32'($signed(ir[15:0]));
    assign pc_inc  = pc + 32'd4;
    assign pc_br   = pc_inc + {off32[29:0], 2'b00};
    assign is_r    = (op == OP_R);
    assign is_addi = (op == OP_ADDI);
    assign is_beq  = (op == OP_BEQ);

    assign busy   = (state == S_FETCH) || (state == S_DECODE) ||
                    (state == S_EXEC)  || (state == S_WB);
    assign halted = (state == S_HALT);
    assign pc_out = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_HALT: begin
                if (run) state_nxt = S_FETCH;
            end
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = (op == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC:   state_nxt = S_WB;
            S_WB:     state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Unknown opcodes and functs leave wb_nxt low and fall through as nops.
    always_comb begin
        y_nxt    = '0;
        dest_nxt = rd;
        wb_nxt   = 1'b0;
        take     = 1'b0;
        unique case (1'b1)
            is_r: begin
                wb_nxt = 1'b1;
                case (funct)
                    F_ADD:   y_nxt = a + b;
                    F_SUB:   y_nxt = a - b;
                    F_AND:   y_nxt = a & b;
                    F_OR:    y_nxt = a | b;
                    F_SLT:   y_nxt[0] = $signed(a) < $signed(b);
                    default: wb_nxt = 1'b0;
                endcase
            end
            is_addi: begin
                y_nxt    = a + imm;
                dest_nxt = rt;
                wb_nxt   = 1'b1;
            end
            is_beq: begin
                take = (a == b);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (imem_we && !busy && !rst) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= PC_RESET;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            y         <= '0;
            dest      <= '0;
            wb_en     <= 1'b0;
            out_G     <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                S_IDLE, S_HALT: begin
                    if (run) pc <= PC_RESET;
                end
                S_FETCH: begin
                    ir <= imem[pc[AW+1:2]];
                end
                S_DECODE: begin
                    a <= regs[rs];
                    b <= regs[rt];
                end
                S_EXEC: begin
                    y     <= y_nxt;
                    dest  <= dest_nxt;
                    wb_en <= wb_nxt;
                    pc    <= (take ? pc_br : pc_inc) & PC_MASK;
                end
                S_WB: begin
                    if (wb_en) begin
                        if (dest != 5'd0) regs[dest] <= y;
                        out_G     <= y;
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_datapath_core.sv
// Scoreboard bench for mc_datapath_core: an ISA-level register model
// predicts every write-back result as programs are assembled.
`timescale 1ns/1ps
module tb_mc_datapath_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_we = 1'b0;
    logic [5:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic        run = 1'b0;
    logic [31:0] out_G;
    logic        out_valid;
    logic        busy;
    logic        halted;
    logic [31:0] pc_out;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] sb [$];
    logic [31:0] prog [$];
    logic [31:0] mr [32];

    localparam int ADD = 'h20;
    localparam int SUB = 'h22;
    localparam int AND = 'h24;
    localparam int OR  = 'h25;
    localparam int SLT = 'h2A;
    localparam logic [31:0] HALT = {6'h3F, 26'd0};

    mc_datapath_core dut (
        .clk        (clk),
        .rst        (rst),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .run        (run),
        .out_G      (out_G),
        .out_valid  (out_valid),
        .busy       (busy),
        .halted     (halted),
        .pc_out     (pc_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [31:0] e;
        if (out_valid === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL wb_pulse: got out_G=%h, required no pulse", out_G);
            end else begin
                e = sb.pop_front();
                if (out_G !== e) begin
                    miscompares++;
                    $display("FAIL wb_value: got %h, required %h", out_G, e);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] enc_r(int rd, int rs, int rt, int funct);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, funct[5:0]};
    endfunction

    task automatic model_reset;
        foreach (mr[i]) mr[i] = '0;
        sb.delete();
        prog.delete();
    endtask

    task automatic emit_addi(int rt, int rs, int imm);
        logic [15:0] i16;
        logic [31:0] v;
        i16 = imm[15:0];
        v = mr[rs] + {{16{i16[15]}}, i16};
        prog.push_back(enc_i('h08, rs, rt, imm));
        sb.push_back(v);
        if (rt != 0) mr[rt] = v;
    endtask

    task automatic emit_r(int rd, int rs, int rt, int funct);
        logic [31:0] x;
        logic [31:0] z;
        logic [31:0] v;
        logic        ok;
        x = mr[rs];
        z = mr[rt];
        ok = 1'b1;
        v = '0;
        case (funct)
            ADD:     v = x + z;
            SUB:     v = x - z;
            AND:     v = x & z;
            OR:      v = x | z;
            SLT:     v = ($signed(x) < $signed(z)) ? 32'd1 : 32'd0;
            default: ok = 1'b0;
        endcase
        prog.push_back(enc_r(rd, rs, rt, funct));
        if (ok) begin
            sb.push_back(v);
            if (rd != 0) mr[rd] = v;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic load_prog;
        foreach (prog[i]) begin
            imem_we = 1'b1;
            imem_waddr = 6'(i);
            imem_wdata = prog[i];
            tick();
        end
        imem_we = 1'b0;
        prog.delete();
    endtask

    task automatic start_run;
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int max);
        int n;
        n = 0;
        while (halted !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        vectors++;
        if (halted !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_timeout: got halted=%b after %0d cycles, required 1",
                     name, halted, n);
        end
    endtask

    task automatic test_reset;
        do_reset();
        vectors += 5;
        if (out_G !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_out_G: got %h, required 0", out_G);
        end
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_out_valid: got %b, required 0", out_valid);
        end
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_busy: got %b, required 0", busy);
        end
        if (halted !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_halted: got %b, required 0", halted);
        end
        if (pc_out !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_pc: got %h, required 0", pc_out);
        end
    endtask

    task automatic test_basic;
        int seen [$];
        do_reset();
        emit_addi(1, 0, 5);
        emit_addi(2, 0, 7);
        emit_r(3, 1, 2, ADD);
        prog.push_back(HALT);
        load_prog();
        run = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) run = 1'b0;
            if (out_valid === 1'b1) seen.push_back(i);
        end
        vectors += 6;
        if (seen.size() != 3) begin
            miscompares++;
            $display("FAIL basic_pulses: got %0d, required 3", seen.size());
        end else if (seen[0] != 5 || seen[1] != 9 || seen[2] != 13) begin
            miscompares++;
            $display("FAIL basic_timing: got %0d,%0d,%0d, required 5,9,13",
                     seen[0], seen[1], seen[2]);
        end
        if (halted !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_halted: got %b, required 1", halted);
        end
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy: got %b, required 0", busy);
        end
        if (pc_out !== 32'd12) begin
            miscompares++;
            $display("FAIL basic_pc: got %h, required 0000000c", pc_out);
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL basic_drain: got %0d pending, required 0", sb.size());
        end
        if (out_G !== 32'd12) begin
            miscompares++;
            $display("FAIL basic_hold: got %h, required 0000000c", out_G);
        end
    endtask

    task automatic test_alu_wrap;
        int hpc;
        do_reset();
        emit_addi(1, 0, 'h8000);
        repeat (16) emit_r(1, 1, 1, ADD);
        emit_addi(1, 1, -1);
        emit_addi(2, 0, 1);
        emit_r(7, 1, 2, OR);
        emit_r(3, 1, 2, ADD);
        emit_r(4, 1, 2, SLT);
        emit_r(4, 3, 2, SLT);
        emit_r(8, 3, 1, AND);
        emit_r(9, 2, 1, SUB);
        emit_r(10, 1, 2, 'h03);
        emit_r(11, 4, 9, ADD);
        prog.push_back(HALT);
        hpc = (prog.size() - 1) * 4;
        load_prog();
        start_run();
        wait_halt("alu", 400);
        vectors += 2;
        if (pc_out !== 32'(hpc)) begin
            miscompares++;
            $display("FAIL alu_pc: got %h, required %h", pc_out, 32'(hpc));
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL alu_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_r0;
        do_reset();
        emit_addi(0, 0, 9);
        emit_r(5, 0, 0, ADD);
        emit_addi(6, 0, -3);
        emit_r(12, 6, 0, SLT);
        prog.push_back(HALT);
        load_prog();
        start_run();
        wait_halt("r0", 100);
        vectors += 2;
        if (pc_out !== 32'd16) begin
            miscompares++;
            $display("FAIL r0_pc: got %h, required 00000010", pc_out);
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL r0_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_branch;
        do_reset();
        emit_addi(1, 0, 1);
        prog.push_back(enc_i('h04, 1, 0, 1));
        emit_addi(2, 0, 2);
        prog.push_back(enc_i('h04, 0, 0, 1));
        prog.push_back(enc_i('h08, 0, 3, 99));
        emit_addi(4, 0, 4);
        prog.push_back(HALT);
        load_prog();
        start_run();
        wait_halt("branch", 100);
        vectors += 2;
        if (pc_out !== 32'd24) begin
            miscompares++;
            $display("FAIL branch_pc: got %h, required 00000018", pc_out);
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL branch_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_branch_loop;
        int late;
        do_reset();
        emit_addi(1, 0, 5);
        prog.push_back(enc_i('h04, 0, 0, -1));
        load_prog();
        start_run();
        late = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i >= 10) begin
                vectors++;
                if (pc_out !== 32'd4) begin
                    miscompares++;
                    $display("FAIL loop_pc: got %h, required 00000004", pc_out);
                end
                if (out_valid === 1'b1) late++;
            end
        end
        vectors += 4;
        if (late != 0) begin
            miscompares++;
            $display("FAIL loop_quiet: got %0d pulses, required 0", late);
        end
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL loop_busy: got %b, required 1", busy);
        end
        if (out_G !== 32'd5) begin
            miscompares++;
            $display("FAIL loop_out_G: got %h, required 00000005", out_G);
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL loop_drain: got %0d pending, required 0", sb.size());
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors += 4;
        if (busy !== 1'b0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL loop_rst_state: got busy=%b halted=%b, required 0 0",
                     busy, halted);
        end
        if (pc_out !== 32'd0) begin
            miscompares++;
            $display("FAIL loop_rst_pc: got %h, required 0", pc_out);
        end
        if (out_G !== 32'd0) begin
            miscompares++;
            $display("FAIL loop_rst_out_G: got %h, required 0", out_G);
        end
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL loop_rst_valid: got %b, required 0", out_valid);
        end
        model_reset();
    endtask

    task automatic test_reset_abort;
        do_reset();
        prog.push_back(enc_i('h08, 0, 1, 3));
        prog.push_back(HALT);
        load_prog();
        start_run();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        repeat (6) tick();
        vectors += 2;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_busy: got %b, required 0", busy);
        end
        if (out_G !== 32'd0) begin
            miscompares++;
            $display("FAIL abort_out_G: got %h, required 0", out_G);
        end
        emit_r(2, 1, 0, ADD);
        prog.push_back(HALT);
        load_prog();
        start_run();
        wait_halt("abort", 100);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL abort_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_load_with_run;
        do_reset();
        prog.push_back(enc_i('h08, 0, 5, 11));
        prog.push_back(HALT);
        load_prog();
        imem_we = 1'b1;
        imem_waddr = 6'd0;
        imem_wdata = enc_i('h08, 0, 5, 77);
        sb.push_back(32'd77);
        start_run();
        imem_we = 1'b0;
        wait_halt("loadrun", 100);
        vectors += 2;
        if (pc_out !== 32'd4) begin
            miscompares++;
            $display("FAIL loadrun_pc: got %h, required 00000004", pc_out);
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL loadrun_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        emit_addi(1, 1, 1);
        prog.push_back(HALT);
        load_prog();
        run = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            imem_we = 1'b0;
            run = 1'b0;
            if (i == 1) begin
                imem_we = 1'b1;
                imem_waddr = 6'd0;
                imem_wdata = enc_i('h08, 0, 1, 100);
            end
            if (i == 2) run = 1'b1;
        end
        imem_we = 1'b0;
        run = 1'b0;
        wait_halt("busy_ign", 100);
        vectors += 2;
        if (pc_out !== 32'd4) begin
            miscompares++;
            $display("FAIL busy_ign_pc: got %h, required 00000004", pc_out);
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL busy_ign_drain: got %0d pending, required 0", sb.size());
        end
        sb.push_back(32'd2);
        start_run();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rerun_busy: got %b, required 1", busy);
        end
        wait_halt("rerun", 100);
        vectors += 2;
        if (pc_out !== 32'd4) begin
            miscompares++;
            $display("FAIL rerun_pc: got %h, required 00000004", pc_out);
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL rerun_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_alu_wrap();
        test_r0();
        test_branch();
        test_branch_loop();
        test_reset_abort();
        test_load_with_run();
        test_back_to_back();
        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
